// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse receiver timer block.
// Timer ids, per-timer threshold multipliers and timer FSM states.
package morse_pkg;

  typedef enum logic [1:0] {
    TMR_BTN   = 2'd0,
    TMR_DASH  = 2'd1,
    TMR_INTER = 2'd2,
    TMR_WORD  = 2'd3
  } timer_id_t;

  localparam int NUM_TIMERS = 4;

  // Threshold = MULT * unit length, indexed by timer_id_t
  localparam logic [3:0] TIMER_MULT [NUM_TIMERS] = '{
    4'd10, // TMR_BTN
    4'd2,  // TMR_DASH
    4'd3,  // TMR_INTER
    4'd7   // TMR_WORD
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } tmr_state_t;

endpackage

// File: rtl/morse_timer.sv
// One restartable ms timeout timer with a sticky done flag.
// Counts ms ticks while running; done when the count reaches limit.
module morse_timer
  import morse_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             done,
  output logic             active
);

  tmr_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             done_q;
  logic             active_q;

  // Next count value when a tick lands in RUN
  always_comb begin
    cnt_inc = cnt_q + CNT_W'(1);
  end

  // Timer FSM: restart wins over tick; done/active are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else if (res) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b1;
    end else if (state_q == S_RUN && tick) begin
      cnt_q <= cnt_inc;
      if (cnt_inc == limit) begin
        state_q  <= S_DONE;
        done_q   <= 1'b1;
        active_q <= 1'b0;
      end
    end
  end

  assign done   = done_q;
  assign active = active_q;

endmodule

// File: rtl/morse_timer_ctrl.sv
// Four Morse receiver timeout timers on a shared 1 ms prescaler.
// Unit length reloads via valid/ready only while all timers are idle.
module morse_timer_ctrl
  import morse_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int UNIT_W       = 10,
  parameter int UNIT_DEFAULT = 120
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              btn_to_res,
  input  logic              dash_to_res,
  input  logic              inter_to_res,
  input  logic              word_to_res,
  output logic              btn_to,
  output logic              dash_to,
  output logic              inter_to,
  output logic              word_to,
  input  logic [UNIT_W-1:0] cfg_unit_ms,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              busy,
  output logic              ms_tick
);

  localparam int CNT_W = UNIT_W + 4;
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]         presc_q;
  logic [PW-1:0]         presc_d;
  logic [UNIT_W-1:0]     unit_q;
  logic [UNIT_W-1:0]     unit_d;
  logic                  tick;
  logic [NUM_TIMERS-1:0] res;
  logic [NUM_TIMERS-1:0] done;
  logic [NUM_TIMERS-1:0] active;
  logic [CNT_W-1:0]      limit [NUM_TIMERS];

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // Free-running prescaler and unit reload on handshake
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    unit_d  = unit_q;
    if (cfg_valid && cfg_ready) begin
      unit_d = (cfg_unit_ms == '0) ? UNIT_W'(1) : cfg_unit_ms;
    end
  end

  // Prescaler and unit length registers
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      unit_q  <= UNIT_W'(UNIT_DEFAULT);
    end else begin
      presc_q <= presc_d;
      unit_q  <= unit_d;
    end
  end

  assign res[TMR_BTN]   = btn_to_res;
  assign res[TMR_DASH]  = dash_to_res;
  assign res[TMR_INTER] = inter_to_res;
  assign res[TMR_WORD]  = word_to_res;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tmr
    assign limit[i] = CNT_W'(TIMER_MULT[i]) * CNT_W'(unit_q);

    morse_timer #(
      .CNT_W(CNT_W)
    ) u_tmr (
      .clk   (clk_100MHz),
      .rst_n (reset_n),
      .res   (res[i]),
      .tick  (tick),
      .limit (limit[i]),
      .done  (done[i]),
      .active(active[i])
    );
  end

  assign btn_to    = done[TMR_BTN];
  assign dash_to   = done[TMR_DASH];
  assign inter_to  = done[TMR_INTER];
  assign word_to   = done[TMR_WORD];
  assign busy      = |active;
  assign cfg_ready = ~busy;
  assign ms_tick   = tick;

endmodule

// File: tb/tb_morse_timer_ctrl.sv
// Self-checking bench for morse_timer_ctrl.
// Expected timeout windows queue on restart and pop on done.
module tb_morse_timer_ctrl;

  typedef struct {
    int idx;
    int lo;
    int hi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] res_v = '0;
  logic [3:0] to_v;
  logic [9:0] cfg_unit = '0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic       busy;
  logic       ms_tick;
  logic       btn_to, dash_to, inter_to, word_to;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign to_v = {word_to, inter_to, dash_to, btn_to};

  morse_timer_ctrl #(
    .TICK_DIV(4),
    .UNIT_W(10),
    .UNIT_DEFAULT(5)
  ) dut (
    .clk_100MHz  (clk),
    .reset_n     (rst_n),
    .btn_to_res  (res_v[0]),
    .dash_to_res (res_v[1]),
    .inter_to_res(res_v[2]),
    .word_to_res (res_v[3]),
    .btn_to      (btn_to),
    .dash_to     (dash_to),
    .inter_to    (inter_to),
    .word_to     (word_to),
    .cfg_unit_ms (cfg_unit),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .busy        (busy),
    .ms_tick     (ms_tick)
  );

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse restart(s); optionally queue the expected done window
  task automatic pulse(input logic [3:0] m, input int lo, input int hi,
                       input bit push);
    @(posedge clk);
    #1 res_v = m;
    @(posedge clk);
    #1;
    t0 = cyc;
    res_v = '0;
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i]) sb.push_back('{i, lo, hi});
      end
    end
  endtask

  // Wait for the front scoreboard timer to finish and check latency
  task automatic wait_done();
    exp_t e;
    int lat;
    bit seen;
    e = sb.pop_front();
    seen = 0;
    lat = 0;
    for (int k = 0; k < e.hi + 20 && !seen; k++) begin
      step(1);
      if (to_v[e.idx]) begin
        seen = 1;
        lat = cyc - t0;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL done_timeout tmr=%0d no done within %0d cycles",
               e.idx, e.hi + 20);
    end else if (lat < e.lo || lat > e.hi) begin
      n_bad++;
      $display("FAIL done_latency tmr=%0d got=%0d want=%0d..%0d",
               e.idx, lat, e.lo, e.hi);
    end
  endtask

  task automatic test_reset();
    int last;
    int nt;
    int gap_bad;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    n_cmp++;
    if ({to_v, busy, cfg_ready} !== 6'b000001) begin
      n_bad++;
      $display("FAIL reset_outs got=%b want=000001",
               {to_v, busy, cfg_ready});
    end
    last = -1;
    nt = 0;
    gap_bad = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (ms_tick) begin
        if (last >= 0 && cyc - last != 4) gap_bad++;
        last = cyc;
        nt++;
      end
    end
    n_cmp++;
    if (nt != 4 || gap_bad != 0) begin
      n_bad++;
      $display("FAIL ms_tick got=%0d ticks %0d bad gaps want=4 ticks 0",
               nt, gap_bad);
    end
  endtask

  task automatic test_dash();
    pulse(4'b0010, 37, 40, 1);
    n_cmp++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL dash_busy got=%b%b want=10", busy, cfg_ready);
    end
    wait_done();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL dash_busy_fall got=%b want=0", busy);
    end
    step(20);
    n_cmp++;
    if (dash_to !== 1'b1) begin
      n_bad++;
      $display("FAIL dash_sticky got=%b want=1", dash_to);
    end
  endtask

  task automatic test_word_restart();
    pulse(4'b1000, 0, 0, 0);
    step(58);
    n_cmp++;
    if (word_to !== 1'b0) begin
      n_bad++;
      $display("FAIL word_early got=%b want=0", word_to);
    end
    pulse(4'b1000, 137, 140, 1);
    n_cmp++;
    if (word_to !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL word_restart got=%b%b want=01", word_to, busy);
    end
    wait_done();
  endtask

  task automatic test_cfg_hold();
    int held;
    pulse(4'b0100, 57, 60, 1);
    cfg_unit = 10'd2;
    cfg_valid = 1'b1;
    held = 0;
    for (int k = 0; k < 80 && !inter_to; k++) begin
      step(1);
      if (!inter_to && cfg_ready) held++;
    end
    n_cmp++;
    if (held != 0) begin
      n_bad++;
      $display("FAIL cfg_ready_busy got=%0d ready cycles want=0", held);
    end
    n_cmp++;
    if (inter_to !== 1'b1 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cfg_release got=%b%b want=11", inter_to, cfg_ready);
    end
    void'(sb.pop_front());
    step(1);
    cfg_valid = 1'b0;
    pulse(4'b0100, 21, 24, 1);
    wait_done();
  endtask

  task automatic test_cfg_zero();
    cfg_unit = 10'd0;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    pulse(4'b0001, 37, 40, 1);
    wait_done();
  endtask

  task automatic test_async_reset();
    pulse(4'b1111, 0, 0, 0);
    step(10);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({to_v, busy, cfg_ready} !== 6'b000001) begin
      n_bad++;
      $display("FAIL async_reset got=%b want=000001",
               {to_v, busy, cfg_ready});
    end
    step(2);
    rst_n = 1'b1;
    step(2);
    n_cmp++;
    if ({to_v, busy} !== 5'b00000) begin
      n_bad++;
      $display("FAIL post_reset got=%b want=00000", {to_v, busy});
    end
    pulse(4'b0010, 37, 40, 1);
    wait_done();
  endtask

  initial begin
    test_reset();
    test_dash();
    test_word_restart();
    test_cfg_hold();
    test_cfg_zero();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
